// File: rtl/ifetch_unit.sv
// Instruction fetch unit: drives imem address, buffers fetched words with PC, hands them to decode.
// Define IFETCH_PERF_EN to build the fetch/stall performance counters; otherwise they read as 0.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] addr,
  input  logic [31:0] data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t        state, state_next;
  logic [31:0]   fetch_pc;
  logic [31:0]   buf_inst [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [PW:0]   count;
  logic          full, pop, push, flush;

  assign full       = (count == FULL_CNT);
  assign inst_valid = (count != '0);
  assign inst       = buf_inst[rd_ptr];
  assign inst_pc    = buf_pc[rd_ptr];
  assign addr       = fetch_pc;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fetch_en)  state_next = RUN;
      RUN:     if (!fetch_en) state_next = HALT;
      HALT:    if (fetch_en)  state_next = RUN;
      default: state_next = IDLE;
    endcase
    pop   = inst_valid && inst_ready;
    flush = redirect_valid && (state != IDLE);
    // a pop frees the tail slot in the same cycle, so a full buffer can still accept
    push  = (state == RUN) && !redirect_valid && (!full || pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
      end
    end else begin
      state <= state_next;
      if (redirect_valid) begin
        fetch_pc <= redirect_pc & ~32'h3;
        if (flush) begin
          rd_ptr <= '0;
          wr_ptr <= '0;
          count  <= '0;
        end
      end else begin
        if (push) begin
          buf_inst[wr_ptr] <= data;
          buf_pc[wr_ptr]   <= fetch_pc;
          wr_ptr           <= wr_ptr + 1'b1;
          fetch_pc         <= fetch_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_q, stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= '0;
      stall_q <= '0;
    end else begin
      if (push) fetch_q <= fetch_q + 32'd1;
      if ((state == RUN) && full && !pop) stall_q <= stall_q + 32'd1;
    end
  end

  assign fetch_cnt = fetch_q;
  assign stall_cnt = stall_q;
`else
  assign fetch_cnt = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: queue-based fetch model checked every cycle plus directed literal checks.
module tb_ifetch_unit;
  localparam int unsigned  DEPTH    = 2;
  localparam logic [31:0]  RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid, inst_valid, inst_ready;
  logic [31:0] addr, data, redirect_pc, inst, inst_pc, fetch_cnt, stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign data = imem_word(addr);

  ifetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .addr(addr), .data(data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: actual 0x%h required 0x%h", name, $time, act, exp);
    end
  endtask

  // Model: the buffer is a queue of {pc, word}; "started" means fetch_en has been seen since
  // reset, and fetching happens on an edge exactly when fetch_en was high at the previous edge.
  logic [63:0] mq[$];
  logic [31:0] m_pc, m_fetch, m_stall;
  bit          m_started, m_running, m_live = 0, m_pop, m_push;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_pc      = RESET_PC;
      m_started = 0;
      m_running = 0;
      m_fetch   = 0;
      m_stall   = 0;
      m_live    = 1;
    end else if (m_live) begin
      m_pop  = (mq.size() != 0) && inst_ready;
      m_push = m_running && !redirect_valid && ((mq.size() < DEPTH) || m_pop);
      if (m_running && mq.size() == DEPTH && !m_pop) m_stall++;
      if (redirect_valid) begin
        if (m_started) mq.delete();
        m_pc = redirect_pc & ~32'h3;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back({m_pc, imem_word(m_pc)});
          m_pc = m_pc + 32'd4;
          m_fetch++;
        end
      end
      if (fetch_en) m_started = 1;
      m_running = fetch_en;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("addr", addr, m_pc);
      check("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
        check("inst_pc", inst_pc, mq[0][63:32]);
        check("inst", inst, mq[0][31:0]);
      end
`ifdef IFETCH_PERF_EN
      check("fetch_cnt", fetch_cnt, m_fetch);
      check("stall_cnt", stall_cnt, m_stall);
`else
      check("fetch_cnt", fetch_cnt, 32'h0);
      check("stall_cnt", stall_cnt, 32'h0);
`endif
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    step(2);
    rst = 1'b0;
    check("rst_addr", addr, 32'h0);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_fetch_cnt", fetch_cnt, 32'h0);

    // fill with decode stalled for five RUN cycles
    fetch_en = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 1) check("first_addr", addr, 32'h0);
      if (i == 2) begin
        check("first_valid", 32'(inst_valid), 32'h1);
        check("first_inst_pc", inst_pc, 32'h0);
        check("first_inst", inst, 32'h1000_0000);
      end
    end
    check("full_addr", addr, 32'h8);
    check("full_inst_pc", inst_pc, 32'h0);
`ifdef IFETCH_PERF_EN
    check("full_stall_cnt", stall_cnt, 32'd3);
    check("full_fetch_cnt", fetch_cnt, 32'd2);
`endif

    inst_ready = 1'b1;
    step();
    check("drain1_inst_pc", inst_pc, 32'h4);
    check("drain1_addr", addr, 32'hC);
    step();
    check("drain2_inst_pc", inst_pc, 32'h8);
    check("drain2_addr", addr, 32'h10);
    step(3);

    // redirect with two entries buffered
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    step();
    redirect_valid = 1'b0;
    check("redir_valid", 32'(inst_valid), 32'h0);
    check("redir_addr", addr, 32'h100);
    step();
    check("redir_inst_pc", inst_pc, 32'h100);
    check("redir_inst", inst, 32'h1000_0040);
    step(4);

    // halt, drain, resume
    fetch_en = 1'b0;
    step(4);
    check("halt_valid", 32'(inst_valid), 32'h0);
    check("halt_addr", addr, 32'h118);
    fetch_en = 1'b1;
    step();
    check("resume_valid", 32'(inst_valid), 32'h0);
    step();
    check("resume_inst_pc", inst_pc, 32'h118);
    step(2);

    // wrap at the top of the address space
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr0", addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr1", addr, 32'h0);
    check("wrap_inst_pc0", inst_pc, 32'hFFFF_FFFC);
    check("wrap_inst0", inst, 32'h4FFF_FFFF);
    step();
    check("wrap_inst_pc1", inst_pc, 32'h0);
    check("wrap_inst1", inst, 32'h1000_0000);

    // reset beats a redirect while full
    inst_ready = 1'b0;
    step(3);
    rst = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; fetch_en = 1'b0;
    step();
    rst = 1'b0; redirect_valid = 1'b0;
    check("rst2_valid", 32'(inst_valid), 32'h0);
    check("rst2_addr", addr, RESET_PC);
    check("rst2_fetch_cnt", fetch_cnt, 32'h0);
    check("rst2_stall_cnt", stall_cnt, 32'h0);
    step(3);
    check("idle_addr", addr, RESET_PC);
    check("idle_valid", 32'(inst_valid), 32'h0);

    // redirect in IDLE only moves the PC
    redirect_valid = 1'b1; redirect_pc = 32'h41;
    step();
    redirect_valid = 1'b0;
    check("idle_redir_addr", addr, 32'h40);
    check("idle_redir_valid", 32'(inst_valid), 32'h0);
    fetch_en = 1'b1; inst_ready = 1'b1;
    step(2);
    check("idle_redir_inst_pc", inst_pc, 32'h40);
    check("idle_redir_inst_valid", 32'(inst_valid), 32'h1);
    step(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
